// File: rtl/uart_pkg.sv
// Shared definitions for the serial peripheral (receiver and transmitter).
// - rx_state_t : receiver FSM states
// - SR_*       : status_register bit positions (SR_BUSY is shared with the transmitter)
// - CR_*       : control_register bit positions
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int SR_BUSY    = 0;
  localparam int SR_READY   = 1;
  localparam int SR_OVERRUN = 2;
  localparam int SR_FRAMING = 3;

  localparam int CR_ENABLE  = 0;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an idle-high asynchronous line.
// Ports:
//   clock - system clock
//   reset - synchronous active-high reset; both flops go to 1 (line idle)
//   d     - asynchronous input
//   q     - synchronised output
module uart_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a register-style host interface.
// Ports:
//   clock            - system clock, rising edge
//   reset            - synchronous active-high reset
//   rx               - asynchronous serial line, idle high
//   control_register - bit0 rx_enable, other bits ignored
//   read_rx_data     - one-cycle strobe: host has consumed rx_data
//   rx_data          - last accepted byte
//   status_register  - bit0 busy, bit1 data_ready, bit2 overrun, bit3 framing_error
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic [7:0] control_register,
  input  logic       read_rx_data,
  output logic [7:0] rx_data,
  output logic [7:0] status_register
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       data_n;
  logic             ready, ready_n;
  logic             ovr, ovr_n;
  logic             frm, frm_n;
  logic             brk, brk_n;     // waiting for the line to return high after a framing error
  logic             rx_s;
  logic             enable;
  logic             unused_cr;

  assign enable    = control_register[CR_ENABLE];
  assign unused_cr = ^control_register[7:1];

  uart_sync2 u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      rx_data <= 8'h00;
      ready   <= 1'b0;
      ovr     <= 1'b0;
      frm     <= 1'b0;
      brk     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      rx_data <= data_n;
      ready   <= ready_n;
      ovr     <= ovr_n;
      frm     <= frm_n;
      brk     <= brk_n;
    end
  end

  // Shift register carries only data; its content is meaningless until a full frame is in.
  always_ff @(posedge clock) begin
    shift <= shift_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    bit_n   = bit_idx;
    shift_n = shift;
    data_n  = rx_data;
    ready_n = ready;
    ovr_n   = ovr;
    frm_n   = frm;
    brk_n   = brk;

    // The read is applied first so that a commit in the same cycle sees the
    // byte as already consumed: the new byte loads and no overrun is raised.
    if (read_rx_data) begin
      ready_n = 1'b0;
      ovr_n   = 1'b0;
      frm_n   = 1'b0;
    end

    if (!enable && state != IDLE) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (brk && rx_s) brk_n = 1'b0;
          if (enable && !brk && !rx_s) state_n = START;
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt_n = '0;
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              bit_n   = 3'd0;
            end
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt_n   = '0;
            shift_n = {rx_s, shift[7:1]};
            bit_n   = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_n = STOP;
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt_n   = '0;
            state_n = IDLE;
            if (rx_s) begin
              if (ready_n) begin
                ovr_n = 1'b1;
              end else begin
                data_n  = shift;
                ready_n = 1'b1;
              end
            end else begin
              frm_n = 1'b1;
              brk_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    status_register             = 8'h00;
    status_register[SR_BUSY]    = (state != IDLE);
    status_register[SR_READY]   = ready;
    status_register[SR_OVERRUN] = ovr;
    status_register[SR_FRAMING] = frm;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLKS_PER_BIT=16 and a 20 ns clock.
// Frames are bit-banged by a transmitter model; outputs are sampled 1 ns after the rising edge.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] control_register = 8'h01;
  logic       read_rx_data = 1'b0;
  logic [7:0] rx_data;
  logic [7:0] status_register;

  int checks = 0;
  int errors = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock            (clock),
    .reset            (reset),
    .rx               (rx),
    .control_register (control_register),
    .read_rx_data     (read_rx_data),
    .rx_data          (rx_data),
    .status_register  (status_register)
  );

  always #10 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       do_read;
    logic [7:0] exp_rx;
    logic [7:0] exp_sr;
  } vec_t;

  vec_t vecs[9];

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic pulse_read();
    read_rx_data = 1'b1;
    tick(1);
    read_rx_data = 1'b0;
    tick(1);
  endtask

  initial begin
    vecs[0] = '{8'h48, 1'b1, 8'h48, 8'h02};
    vecs[1] = '{8'h65, 1'b1, 8'h65, 8'h02};
    vecs[2] = '{8'h6C, 1'b1, 8'h6C, 8'h02};
    vecs[3] = '{8'h6C, 1'b1, 8'h6C, 8'h02};
    vecs[4] = '{8'h6F, 1'b1, 8'h6F, 8'h02};
    vecs[5] = '{8'h21, 1'b1, 8'h21, 8'h02};
    vecs[6] = '{8'h20, 1'b1, 8'h20, 8'h02};
    vecs[7] = '{8'h55, 1'b0, 8'h55, 8'h02};
    vecs[8] = '{8'hAA, 1'b1, 8'h55, 8'h06};

    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset_sr", status_register, 8'h00);
    check("reset_data", rx_data, 8'h00);

    // Loop-back bytes and overrun
    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].data, 1'b1);
      tick(2);
      check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_rx);
      check($sformatf("vec%0d_sr", i), status_register, vecs[i].exp_sr);
      if (vecs[i].do_read) begin
        pulse_read();
        check($sformatf("vec%0d_sr_read", i), status_register, 8'h00);
        check($sformatf("vec%0d_data_read", i), rx_data, vecs[i].exp_rx);
      end
    end

    // Framing error followed by a held-low break
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(bit'(8'h3C >> i));
    rx = 1'b0;
    tick(3 * CPB);
    check("frm_sr_break", status_register, 8'h08);
    check("frm_data_kept", rx_data, 8'h55);
    rx = 1'b1;
    tick(CPB);
    check("frm_sr_idle", status_register, 8'h08);
    send_frame(8'h3C, 1'b1);
    tick(2);
    check("frm_next_data", rx_data, 8'h3C);
    check("frm_next_sr", status_register, 8'h0A);
    pulse_read();
    check("frm_read_sr", status_register, 8'h00);

    // Glitch: 4-cycle low pulse is a false start
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    check("glitch_busy", status_register, 8'h01);
    tick(20);
    check("glitch_sr", status_register, 8'h00);
    check("glitch_data", rx_data, 8'h3C);

    // Disabled while idle: frame ignored
    control_register = 8'h00;
    send_frame(8'h11, 1'b1);
    tick(2);
    check("dis_idle_sr", status_register, 8'h00);
    check("dis_idle_data", rx_data, 8'h3C);

    // Disable mid-frame during bit 3 of 8'hF0
    control_register = 8'hFF;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(bit'(8'hF0 >> i));
    rx = 1'b0;
    tick(CPB / 2);
    control_register = 8'hFE;
    tick(1);
    check("dis_mid_sr", status_register, 8'h00);
    check("dis_mid_data", rx_data, 8'h3C);
    tick(CPB / 2 - 1);
    for (int i = 4; i < 8; i++) send_bit(bit'(8'hF0 >> i));
    send_bit(1'b1);
    tick(4);
    check("dis_after_sr", status_register, 8'h00);
    control_register = 8'h01;
    send_frame(8'h0F, 1'b1);
    tick(2);
    check("reen_data", rx_data, 8'h0F);
    check("reen_sr", status_register, 8'h02);
    pulse_read();

    // Read strobe coincident with the stop-bit commit of a second byte
    send_frame(8'h7E, 1'b1);
    tick(2);
    check("pend_data", rx_data, 8'h7E);
    check("pend_sr", status_register, 8'h02);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(bit'(8'h81 >> i));
    // Stop bit starts 144 cycles into the frame; the stop sample edge is
    // 155 cycles after the rx fall (2 sync + 1 detect + 8 half bit + 144).
    rx = 1'b1;
    tick(10);
    read_rx_data = 1'b1;
    tick(1);
    read_rx_data = 1'b0;
    tick(5);
    tick(2);
    check("simul_data", rx_data, 8'h81);
    check("simul_sr", status_register, 8'h02);

    // Reset mid-frame
    rx = 1'b0;
    tick(40);
    check("rst_mid_busy", status_register, 8'h03);
    reset = 1'b1;
    rx = 1'b1;
    tick(1);
    check("rst_mid_sr", status_register, 8'h00);
    check("rst_mid_data", rx_data, 8'h00);
    reset = 1'b0;
    tick(20);
    check("rst_after_sr", status_register, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
